pdp8_memseq: RTL



---
 rtl/pdp8_memseq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pdp8_memseq.sv
// PDP-8 memory access sequencer: one req/ack word access at a time, driving
// registered async-SRAM strobes with programmable wait states.
module pdp8_memseq #(
   parameter int unsigned RD_WAIT = 2,
   parameter int unsigned WR_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [14:0] addr,
   input  logic [11:0] wdata,
   output logic [11:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic [14:0] ram_addr,
   output logic [11:0] ram_data_in,
   input  logic [11:0] ram_data_out,
   output logic        ram_rd,
   output logic        ram_wr
);

   typedef enum logic [2:0] {StIdle, StRd, StWsetup, StWpulse, StWhold} state_e;

   localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
   localparam logic [3:0] WrLoad = 4'(WR_WAIT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [14:0] addr_q, addr_d;
   logic [11:0] data_q, data_d;
   logic [11:0] rdata_q, rdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 15'd0;
         data_q  <= 12'd0;
         rdata_q <= 12'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ack_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d = addr;
               data_d = wdata;
               if (we) begin
                  state_d = StWsetup;
                  cnt_d   = WrLoad;
               end else begin
                  state_d = StRd;
                  cnt_d   = RdLoad;
                  rd_d    = 1'b1;
               end
            end
         end
         StRd: begin
            // RD also covers the trailing ack cycle, marked by the strobe being low.
            if (rd_q) begin
               if (cnt_q == 4'd0) begin
                  rdata_d = ram_data_out;
                  ack_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
                  rd_d  = 1'b1;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWsetup: begin
            state_d = StWpulse;
            wr_d    = 1'b1;
         end
         StWpulse: begin
            if (cnt_q == 4'd0) begin
               state_d = StWhold;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
               wr_d  = 1'b1;
            end
         end
         StWhold: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   assign rdata       = rdata_q;
   assign ack         = ack_q;
   assign busy        = busy_q;
   assign ram_addr    = addr_q;
   assign ram_data_in = data_q;
   assign ram_rd      = rd_q;
   assign ram_wr      = wr_q;

endmodule
